// File: rtl/cobra_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cobra_pkg : shared types and default port numbers for the cobra    |
// | bus controller.                          rev 1.0                   |
// +--------------------------------------------------------------------+
package cobra_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_VRAM} region_e;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} bus_fsm_e;

  localparam logic [7:0] c_reloc_port = 8'h1F;
  localparam logic [7:0] c_bank_port  = 8'h1E;

endpackage : cobra_pkg
`default_nettype wire

// File: rtl/cobra_wait_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cobra_wait_gen : holds wait_n low for ws cycles once per access.   |
// |                                          rev 1.0                   |
// +--------------------------------------------------------------------+
module cobra_wait_gen
  import cobra_pkg::*;
(
  input  logic       clk_cpu,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mreq_n,
  input  logic [3:0] ws,
  output logic       wait_n
);

  bus_fsm_e   r_state;
  logic [3:0] r_cnt;
  logic       r_wait_n;

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_wait_n <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && (ws != 4'd0)) begin
            r_cnt    <= ws - 4'd1;
            r_wait_n <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_wait_n <= 1'b1;
            r_state  <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // Stay here until the access ends so one access waits only once.
        HOLD: begin
          if (mreq_n) r_state <= IDLE;
        end
        default: begin
          r_wait_n <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign wait_n = r_wait_n;

endmodule : cobra_wait_gen
`default_nettype wire

// File: rtl/cobra_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cobra_bus_ctrl : Z80 bus decode, boot relocation, banked RAM,      |
// | wait states and registered IO write strobes.   rev 1.0             |
// +--------------------------------------------------------------------+
module cobra_bus_ctrl
  import cobra_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] ROM_BASE   = 16'hC000,
  parameter int                ROM_AW     = 11,
  parameter logic [ADDR_W-1:0] VRAM_BASE  = 16'hF800,
  parameter int                VRAM_AW    = 11,
  parameter logic [ADDR_W-1:0] RELOC_OR   = 16'hC000,
  parameter logic [7:0]        RELOC_PORT = c_reloc_port,
  parameter logic [7:0]        BANK_PORT  = c_bank_port,
  parameter int                BANK_W     = 2,
  parameter logic [ADDR_W-1:0] WIN_BASE   = 16'h8000,
  parameter int                ROM_WS     = 0,
  parameter int                VRAM_WS    = 2
) (
  input  logic                     clk_cpu,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        addr_raw,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     m1_n,
  input  logic [DATA_W-1:0]        cpu_dout,
  output logic [DATA_W-1:0]        cpu_din,
  output logic                     wait_n,
  input  logic [DATA_W-1:0]        rom_di,
  input  logic [DATA_W-1:0]        ram_di,
  input  logic [DATA_W-1:0]        vram_di,
  input  logic [DATA_W-1:0]        io_di,
  output logic [ROM_AW-1:0]        rom_a,
  output logic [ADDR_W+BANK_W-1:0] ram_a,
  output logic [VRAM_AW-1:0]       vram_a,
  output logic [DATA_W-1:0]        mem_do,
  output logic                     ram_w,
  output logic                     vram_w,
  output logic [7:0]               io_port,
  output logic                     io_wr_stb,
  output logic                     io_rd,
  output logic                     reloc_active,
  output logic [BANK_W-1:0]        bank_sel
);

  // Range ends carry one extra bit so regions touching the top of the map compare correctly.
  localparam logic [ADDR_W:0] c_rom_end = {1'b0, ROM_BASE} + (ADDR_W+1)'(2**ROM_AW);
  localparam logic [ADDR_W:0] c_win_end = {1'b0, WIN_BASE} + (ADDR_W+1)'(16384);
  localparam logic [3:0]      c_rom_ws  = 4'(ROM_WS);
  localparam logic [3:0]      c_vram_ws = 4'(VRAM_WS);

  if (ROM_WS > 15 || VRAM_WS > 15 || ROM_WS < 0 || VRAM_WS < 0) begin : g_ws_illegal
    $error("cobra_bus_ctrl: wait-state parameters must be 0..15");
  end

  logic              r_reloc_active;
  logic [BANK_W-1:0] r_bank_sel;
  logic              r_io_wr_stb;
  logic [7:0]        r_io_port;
  logic              r_io_wr_prev;
  logic              r_mreq_n_prev;

  logic [ADDR_W-1:0] w_addr;
  region_e           w_region;
  logic              w_win_hit;
  logic              w_io_cyc;
  logic              w_io_wr;
  logic              w_io_wr_rise;
  logic [3:0]        w_ws;

  assign w_addr    = r_reloc_active ? (addr_raw | RELOC_OR) : addr_raw;
  assign w_win_hit = ({1'b0, w_addr} >= {1'b0, WIN_BASE}) && ({1'b0, w_addr} < c_win_end);

  always_comb begin
    w_region = REG_RAM;
    if (w_addr >= VRAM_BASE)
      w_region = REG_VRAM;
    else if (({1'b0, w_addr} >= {1'b0, ROM_BASE}) && ({1'b0, w_addr} < c_rom_end))
      w_region = REG_ROM;
  end

  always_comb begin
    cpu_din = ram_di;
    w_ws    = 4'd0;
    case (w_region)
      REG_ROM:  begin cpu_din = rom_di;  w_ws = c_rom_ws;  end
      REG_VRAM: begin cpu_din = vram_di; w_ws = c_vram_ws; end
      default:  begin cpu_din = ram_di;  w_ws = 4'd0;      end
    endcase
    if (!iorq_n) cpu_din = io_di;
  end

  assign rom_a  = addr_raw[ROM_AW-1:0];
  assign vram_a = w_addr[VRAM_AW-1:0];
  assign ram_a  = w_win_hit ? {r_bank_sel, w_addr} : {{BANK_W{1'b0}}, w_addr};
  assign mem_do = cpu_dout;
  assign ram_w  = ~mreq_n & ~wr_n & (w_region == REG_RAM);
  assign vram_w = ~mreq_n & ~wr_n & (w_region == REG_VRAM);

  // Interrupt acknowledge also drives IORQ low, but with M1 low; that is never an IO access.
  assign w_io_cyc     = ~iorq_n & m1_n;
  assign io_rd        = w_io_cyc & ~rd_n;
  assign w_io_wr      = w_io_cyc & ~wr_n;
  assign w_io_wr_rise = w_io_wr & ~r_io_wr_prev;

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_reloc_active <= 1'b1;
      r_bank_sel     <= '0;
      r_io_wr_stb    <= 1'b0;
      r_io_port      <= 8'h00;
      r_io_wr_prev   <= 1'b0;
      r_mreq_n_prev  <= 1'b1;
    end else begin
      r_io_wr_prev  <= w_io_wr;
      r_mreq_n_prev <= mreq_n;
      r_io_wr_stb   <= w_io_wr_rise;
      if (w_io_wr_rise) begin
        r_io_port <= addr_raw[7:0];
        if (addr_raw[7:0] == RELOC_PORT) r_reloc_active <= 1'b0;
        if (addr_raw[7:0] == BANK_PORT)  r_bank_sel     <= cpu_dout[BANK_W-1:0];
      end
    end
  end

  assign reloc_active = r_reloc_active;
  assign bank_sel     = r_bank_sel;
  assign io_wr_stb    = r_io_wr_stb;
  assign io_port      = r_io_port;

  cobra_wait_gen u_wait_gen (
    .clk_cpu (clk_cpu),
    .rst_n   (rst_n),
    .start   (~mreq_n & r_mreq_n_prev),
    .mreq_n  (mreq_n),
    .ws      (w_ws),
    .wait_n  (wait_n)
  );

endmodule : cobra_bus_ctrl
`default_nettype wire

// File: tb/tb_cobra_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cobra_bus_ctrl : directed self-checking bench for the cobra     |
// | bus controller.                          rev 1.0                   |
// +--------------------------------------------------------------------+
module tb_cobra_bus_ctrl;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic [15:0] addr_raw;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [7:0]  cpu_dout, cpu_din;
  logic        wait_n;
  logic [7:0]  rom_di, ram_di, vram_di, io_di;
  logic [10:0] rom_a;
  logic [17:0] ram_a;
  logic [10:0] vram_a;
  logic [7:0]  mem_do;
  logic        ram_w, vram_w;
  logic [7:0]  io_port;
  logic        io_wr_stb, io_rd, reloc_active;
  logic [1:0]  bank_sel;

  int vectors    = 0;
  int miscompares = 0;
  int stb_count;

  always #5 clk_cpu = ~clk_cpu;

  cobra_bus_ctrl u_dut (
    .clk_cpu      (clk_cpu),
    .rst_n        (rst_n),
    .addr_raw     (addr_raw),
    .mreq_n       (mreq_n),
    .iorq_n       (iorq_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .m1_n         (m1_n),
    .cpu_dout     (cpu_dout),
    .cpu_din      (cpu_din),
    .wait_n       (wait_n),
    .rom_di       (rom_di),
    .ram_di       (ram_di),
    .vram_di      (vram_di),
    .io_di        (io_di),
    .rom_a        (rom_a),
    .ram_a        (ram_a),
    .vram_a       (vram_a),
    .mem_do       (mem_do),
    .ram_w        (ram_w),
    .vram_w       (vram_w),
    .io_port      (io_port),
    .io_wr_stb    (io_wr_stb),
    .io_rd        (io_rd),
    .reloc_active (reloc_active),
    .bank_sel     (bank_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; addr_raw = 16'h0000; cpu_dout = 8'h00;
    rom_di = 8'hA5; ram_di = 8'h5A; vram_di = 8'h3C; io_di = 8'h77;
    bus_idle();
    tick(); tick();
    check("rst_reloc",   reloc_active, 1);
    check("rst_bank",    bank_sel,     0);
    check("rst_wait",    wait_n,       1);
    check("rst_stb",     io_wr_stb,    0);
    check("rst_io_port", io_port,      0);

    // T1: boot fetch from 0x0000 is relocated into ROM
    rst_n = 1'b1;
    addr_raw = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; #1;
    check("t1_din_rom", cpu_din, 8'hA5);
    check("t1_rom_a",   rom_a,   11'h000);
    check("t1_ram_w",   ram_w,   0);
    tick();
    check("t1_no_wait", wait_n, 1);
    bus_idle(); tick();

    // T2: OUT (0x1F) ends relocation
    addr_raw = 16'h001F; iorq_n = 1'b0; wr_n = 1'b0; tick();
    check("t2_stb",     io_wr_stb,    1);
    check("t2_reloc",   reloc_active, 0);
    check("t2_io_port", io_port,      8'h1F);
    tick();
    check("t2_stb_once", io_wr_stb, 0);
    bus_idle(); tick();
    addr_raw = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; #1;
    check("t2_din_ram", cpu_din, 8'h5A);
    check("t2_ram_a",   ram_a,   18'h00000);
    bus_idle(); tick();

    // T3: bank 3 selected, window and non-window writes
    addr_raw = 16'h001E; cpu_dout = 8'h03; iorq_n = 1'b0; wr_n = 1'b0; tick();
    check("t3_bank", bank_sel, 2'd3);
    bus_idle(); tick();
    addr_raw = 16'h8123; cpu_dout = 8'h42; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("t3_win_a",  ram_a,  18'h38123);
    check("t3_ram_w",  ram_w,  1);
    check("t3_vram_w", vram_w, 0);
    check("t3_mem_do", mem_do, 8'h42);
    bus_idle(); tick();
    addr_raw = 16'hBFFF; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("t3_win_top", ram_a, 18'h3BFFF);
    bus_idle(); tick();
    addr_raw = 16'h4000; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("t3_low_a", ram_a, 18'h04000);
    check("t3_low_w", ram_w, 1);
    bus_idle(); tick();
    addr_raw = 16'hC000; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("t3_rom_wr_drop", ram_w, 0);
    bus_idle(); tick();
    addr_raw = 16'hC7FF; mreq_n = 1'b0; rd_n = 1'b0; #1;
    check("t3_rom_last", cpu_din, 8'hA5);
    check("t3_rom_a",    rom_a,   11'h7FF);
    bus_idle(); tick();
    addr_raw = 16'hC800; mreq_n = 1'b0; rd_n = 1'b0; #1;
    check("t3_past_rom", cpu_din, 8'h5A);
    check("t3_past_a",   ram_a,   18'h0C800);
    bus_idle(); tick();

    // T4: VRAM read with two wait states, no re-trigger
    addr_raw = 16'hF800; mreq_n = 1'b0; rd_n = 1'b0; #1;
    check("t4_vram_a",   vram_a,  11'h000);
    check("t4_din_vram", cpu_din, 8'h3C);
    tick(); check("t4_wait_c1", wait_n, 0);
    tick(); check("t4_wait_c2", wait_n, 0);
    tick(); check("t4_wait_end", wait_n, 1);
    tick(); check("t4_hold1", wait_n, 1);
    tick(); check("t4_hold2", wait_n, 1);
    bus_idle(); tick();
    check("t4_idle", wait_n, 1);
    addr_raw = 16'hF900; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("t4_vram_w",  vram_w, 1);
    check("t4_vram_nr", ram_w,  0);
    check("t4_vram_a2", vram_a, 11'h100);
    tick(); tick(); tick();
    bus_idle(); tick(); tick();

    // T5: int-ack never strobes; held IO write strobes once
    addr_raw = 16'h001E; cpu_dout = 8'h00; iorq_n = 1'b0; m1_n = 1'b0; wr_n = 1'b0; #1;
    check("t5_ack_io_rd", io_rd, 0);
    tick();
    check("t5_ack_stb",  io_wr_stb, 0);
    check("t5_ack_bank", bank_sel,  2'd3);
    check("t5_ack_port", io_port,   8'h1E);
    bus_idle(); tick();
    addr_raw = 16'h0020; iorq_n = 1'b0; wr_n = 1'b0;
    stb_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (io_wr_stb) stb_count++;
    end
    check("t5_held_stb", stb_count, 1);
    check("t5_held_port", io_port, 8'h20);
    bus_idle(); tick();
    addr_raw = 16'h0010; iorq_n = 1'b0; rd_n = 1'b0; #1;
    check("t5_io_rd",  io_rd,   1);
    check("t5_io_din", cpu_din, 8'h77);
    bus_idle(); tick();

    // T6: reset during WAIT
    addr_raw = 16'hF800; mreq_n = 1'b0; rd_n = 1'b0; tick();
    check("t6_in_wait", wait_n, 0);
    rst_n = 1'b0; tick();
    check("t6_wait", wait_n,       1);
    check("t6_reloc", reloc_active, 1);
    check("t6_bank", bank_sel,     0);
    bus_idle(); rst_n = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cobra_bus_ctrl
`default_nettype wire
